keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad, synchronizes and debounces the row inputs, and decodes each new press to a hex digit.

---
 rtl/keypad_scanner.sv | 166 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with row synchronizer, press/release debounce and hex decode.
// Rows reach the FSM 2 cycles after the pins; no backpressure, a new digit shifts s0 into s1.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 240000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DBC_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    rows_m, rows_s;
  logic [1:0]    col_idx, col_idx_nxt;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [SW-1:0] dwell, dwell_nxt;
  logic [DW-1:0] dbc, dbc_nxt;
  logic [3:0]    key_code_nxt, s0_nxt, s1_nxt;
  logic          key_valid_nxt;
  logic          row_low;
  logic [1:0]    low_row;

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  assign cols    = ~(4'b0001 << col_idx);
  assign row_low = ~rows_s[row_idx];

  // Lowest-index pressed row wins when several rows read low at once.
  always_comb begin
    low_row = 2'd3;
    if (!rows_s[2]) low_row = 2'd2;
    if (!rows_s[1]) low_row = 2'd1;
    if (!rows_s[0]) low_row = 2'd0;
  end

  always_comb begin
    state_nxt     = state;
    col_idx_nxt   = col_idx;
    row_idx_nxt   = row_idx;
    dwell_nxt     = dwell;
    dbc_nxt       = dbc;
    key_code_nxt  = key_code;
    s0_nxt        = s0;
    s1_nxt        = s1;
    key_valid_nxt = 1'b0;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (rows_s != 4'hF) begin
            row_idx_nxt  = low_row;
            key_code_nxt = decode(low_row, col_idx);
            dbc_nxt      = '0;
            state_nxt    = DEBOUNCE;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_low) begin
          if (dbc == DBC_LAST) begin
            s1_nxt        = s0;
            s0_nxt        = key_code;
            key_valid_nxt = 1'b1;
            state_nxt     = HELD;
          end else begin
            dbc_nxt = dbc + 1'b1;
          end
        end else begin
          col_idx_nxt = col_idx + 2'd1;
          dwell_nxt   = '0;
          state_nxt   = SCAN;
        end
      end
      HELD: begin
        if (!row_low) begin
          dbc_nxt   = '0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!row_low) begin
          if (dbc == DBC_LAST) begin
            col_idx_nxt = col_idx + 2'd1;
            dwell_nxt   = '0;
            state_nxt   = SCAN;
          end else begin
            dbc_nxt = dbc + 1'b1;
          end
        end else begin
          dbc_nxt   = '0;
          state_nxt = HELD;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  // Synchronizer flops reset to the released level so no phantom press follows reset.
  always_ff @(posedge int_osc) begin
    if (reset) begin
      state     <= SCAN;
      rows_m    <= 4'hF;
      rows_s    <= 4'hF;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dwell     <= '0;
      dbc       <= '0;
      key_code  <= 4'h0;
      s0        <= 4'h0;
      s1        <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      rows_m    <= rows;
      rows_s    <= rows_m;
      col_idx   <= col_idx_nxt;
      row_idx   <= row_idx_nxt;
      dwell     <= dwell_nxt;
      dbc       <= dbc_nxt;
      key_code  <= key_code_nxt;
      s0        <= s0_nxt;
      s1        <= s1_nxt;
      key_valid <= key_valid_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad model on rows, scoreboard of expected digits popped on key_valid.
module tb_keypad_scanner;

  logic       int_osc;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] s0, s1, key_code;
  logic       key_valid;

  logic [15:0] key_down;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int t0, t1, kr, base;

  typedef struct packed {
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] code;
  } exp_t;
  exp_t exp_q[$];

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .int_osc  (int_osc),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .s0       (s0),
    .s1       (s1),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  initial int_osc = 1'b0;
  always #5 int_osc = ~int_osc;

  always @(posedge int_osc) cyc++;

  // Key (r,c) pulls row r low while held and column c is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] ec);
    exp_t e;
    e.s0 = e0;
    e.s1 = e1;
    e.code = ec;
    exp_q.push_back(e);
  endtask

  always @(negedge int_osc) begin
    if (key_valid === 1'b1) begin
      exp_t e;
      pulse_cnt++;
      pulse_cyc = cyc;
      chk("pulse_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pulse_s0", s0, e.s0);
        chk("pulse_s1", s1, e.s1);
        chk("pulse_key_code", key_code, e.code);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge int_osc);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cols"}, cols, 4'b1110);
    chk({tag, "_s0"}, s0, 4'h0);
    chk({tag, "_s1"}, s1, 4'h0);
    chk({tag, "_key_valid"}, key_valid, 1'b0);
    chk({tag, "_key_code"}, key_code, 4'h0);
  endtask

  initial begin
    logic [3:0] ecols;
    reset = 1'b1;
    key_down = '0;
    tick(3);
    reset = 1'b0;

    // Idle scan: each column driven for 4 cycles, wrapping back to column 0.
    check_reset_state("t1_reset");
    for (int i = 0; i < 17; i++) begin
      ecols = 4'hF;
      ecols[(i/4)%4] = 1'b0;
      chk("t1_scan_cols", cols, ecols);
      tick(1);
    end
    chk("t1_no_pulse", pulse_cnt, 0);

    // Hold '5': one pulse 8 cycles after debounce entry, column frozen, no auto-repeat.
    do_reset();
    t0 = cyc;
    push_exp(4'h5, 4'h0, 4'h5);
    key_down[5] = 1'b1;
    tick(20);
    chk("t2_pulse_cnt", pulse_cnt, 1);
    chk("t2_pulse_time", pulse_cyc - t0, 16);
    tick(20);
    chk("t2_held_cols", cols, 4'b1101);
    chk("t2_no_repeat", pulse_cnt, 1);
    chk("t2_s0", s0, 4'h5);

    // Release '5', press 'A': scanning resumes only after 8 released cycles.
    push_exp(4'hA, 4'h5, 4'hA);
    kr = cyc;
    key_down[5] = 1'b0;
    key_down[3] = 1'b1;
    tick(10);
    chk("t3_release_hold_cols", cols, 4'b1101);
    tick(1);
    chk("t3_resume_cols", cols, 4'b1011);
    tick(19);
    chk("t3_pulse_cnt", pulse_cnt, 2);
    chk("t3_pulse_time", pulse_cyc - kr, 27);
    key_down[3] = 1'b0;
    tick(20);

    // Bounce on '8' during debounce: dropped, then registered once on the steady press.
    do_reset();
    base = pulse_cnt;
    t0 = cyc;
    push_exp(4'h8, 4'h0, 4'h8);
    key_down[9] = 1'b1;
    tick(9);
    key_down[9] = 1'b0;
    tick(1);
    key_down[9] = 1'b1;
    tick(30);
    chk("t4_pulse_cnt", pulse_cnt - base, 1);
    chk("t4_pulse_time", pulse_cyc - t0, 36);
    tick(10);
    key_down[9] = 1'b0;
    tick(20);
    chk("t4_single_pulse", pulse_cnt - base, 1);
    chk("t4_s0", s0, 4'h8);

    // Hold '1' then add '9': only '1' counts; '9' registers once '1' is released.
    do_reset();
    base = pulse_cnt;
    t0 = cyc;
    push_exp(4'h1, 4'h0, 4'h1);
    key_down[0] = 1'b1;
    tick(14);
    key_down[10] = 1'b1;
    tick(6);
    chk("t5_first_cnt", pulse_cnt - base, 1);
    chk("t5_first_time", pulse_cyc - t0, 12);
    push_exp(4'h9, 4'h1, 4'h9);
    kr = cyc;
    key_down[0] = 1'b0;
    tick(30);
    chk("t5_second_cnt", pulse_cnt - base, 2);
    chk("t5_second_time", pulse_cyc - kr, 27);
    key_down[10] = 1'b0;
    tick(20);

    // Reset clears registered digits, and a reset mid-debounce of 'F' drops the press.
    do_reset();
    check_reset_state("t6_clear");
    base = pulse_cnt;
    key_down[14] = 1'b1;
    tick(14);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_reset_state("t6_mid");
    chk("t6_no_pulse", pulse_cnt - base, 0);
    t1 = cyc;
    push_exp(4'hF, 4'h0, 4'hF);
    tick(24);
    chk("t6_pulse_cnt", pulse_cnt - base, 1);
    chk("t6_pulse_time", pulse_cyc - t1, 20);
    key_down[14] = 1'b0;
    tick(20);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
